// File: rtl/conv2_pkg.sv
// Shared constants and types for the conv2 window sequencer.
// Geometry, data widths and the FSM state encoding live here.
package conv2_pkg;

    localparam int unsigned IN_W     = 12;
    localparam int unsigned IN_H     = 12;
    localparam int unsigned K        = 5;
    localparam int unsigned NUM_FILT = 3;
    localparam int unsigned DW       = 14;
    localparam int unsigned OW       = 12;

    localparam int unsigned OUT_W = IN_W - K + 1;
    localparam int unsigned OUT_H = IN_H - K + 1;

    // Row/column counter width and output coordinate width.
    localparam int unsigned CW = 4;
    localparam int unsigned PW = 3;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

endpackage

// File: rtl/conv2_sched_if.sv
// Pixel-in / result-out handshake bundle for conv2_sched.
// The sequencer uses the slave view; the upstream/downstream side uses master.
interface conv2_sched_if;
    import conv2_pkg::*;

    logic                     pix_valid;
    logic                     pix_ready;
    logic                     out_valid;
    logic                     out_ready;
    logic [NUM_FILT*OW-1:0]   out_data;
    logic [PW-1:0]            out_row;
    logic [PW-1:0]            out_col;

    modport slave (
        input  pix_valid,
        output pix_ready,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_row,
        output out_col
    );

    modport master (
        output pix_valid,
        input  pix_ready,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_row,
        input  out_col
    );

endinterface

// File: rtl/conv2_bias_relu.sv
// Bias add followed by ReLU and saturation to a non-negative OW-bit result.
// Purely combinational; one instance per filter.
module conv2_bias_relu
    import conv2_pkg::*;
(
    input  logic [DW-1:0] conv_i,
    input  logic [DW-1:0] bias_i,
    output logic [OW-1:0] res_o
);

    localparam logic [OW-1:0] ResMax = {1'b0, {(OW-1){1'b1}}};

    logic signed [DW:0] sum;

    always_comb begin
        sum = $signed({conv_i[DW-1], conv_i}) + $signed({bias_i[DW-1], bias_i});
        if (sum[DW]) begin
            res_o = '0;
        end else if (|sum[DW-1:OW-1]) begin
            // Non-negative sum with any bit at or above 2^(OW-1) exceeds the max.
            res_o = ResMax;
        end else begin
            res_o = sum[OW-1:0];
        end
    end

endmodule

// File: rtl/conv2_sched.sv
// Conv2 window sequencer: tracks raster position, strobes win_valid per complete
// 5x5 window and registers bias+ReLU results for the pool2 handshake.
module conv2_sched
    import conv2_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    output logic                   win_valid_o,
    input  logic [NUM_FILT*DW-1:0] conv_in_i,
    input  logic [NUM_FILT*DW-1:0] bias_i,
    output logic                   busy_o,
    output logic                   done_o,
    conv2_sched_if.slave           io
);

    state_e                 state_q;
    logic                   busy_q, done_q;
    logic [CW-1:0]          row_q, row_d;
    logic [CW-1:0]          col_q, col_d;
    logic                   win_q, win_d;
    logic [PW-1:0]          pend_row_q, pend_row_d;
    logic [PW-1:0]          pend_col_q, pend_col_d;
    logic                   out_valid_q, out_valid_d;
    logic [NUM_FILT*OW-1:0] out_data_q, out_data_d;
    logic [PW-1:0]          out_row_q, out_row_d;
    logic [PW-1:0]          out_col_q, out_col_d;

    logic                   stall;
    logic                   pix_ready;
    logic                   accept;
    logic                   last_pix;
    logic                   win_pix;
    logic [NUM_FILT*OW-1:0] res;

    // Holding off input while a result is stuck guarantees a free output slot
    // at every win_valid cycle.
    assign stall     = out_valid_q && !io.out_ready;
    assign pix_ready = (state_q == StRun) && !win_q && !stall;
    assign accept    = pix_ready && io.pix_valid;
    assign last_pix  = (row_q == CW'(IN_H - 1)) && (col_q == CW'(IN_W - 1));
    assign win_pix   = (row_q >= CW'(K - 1)) && (col_q >= CW'(K - 1));

    for (genvar f = 0; f < NUM_FILT; f++) begin : g_filt
        conv2_bias_relu u_bias_relu (
            .conv_i (conv_in_i[f*DW +: DW]),
            .bias_i (bias_i[f*DW +: DW]),
            .res_o  (res[f*OW +: OW])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q <= StRun;
                        busy_q  <= 1'b1;
                    end
                end
                StRun: begin
                    if (accept && last_pix) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (!win_q && !out_valid_q) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        row_d      = row_q;
        col_d      = col_q;
        win_d      = 1'b0;
        pend_row_d = pend_row_q;
        pend_col_d = pend_col_q;
        if ((state_q == StIdle) && start_i) begin
            row_d = '0;
            col_d = '0;
        end else if (accept) begin
            if (col_q == CW'(IN_W - 1)) begin
                col_d = '0;
                row_d = row_q + CW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
            if (win_pix) begin
                win_d      = 1'b1;
                pend_row_d = PW'(row_q - CW'(K - 1));
                pend_col_d = PW'(col_q - CW'(K - 1));
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_row_d   = out_row_q;
        out_col_d   = out_col_q;
        if (win_q) begin
            out_valid_d = 1'b1;
            out_data_d  = res;
            out_row_d   = pend_row_q;
            out_col_d   = pend_col_q;
        end else if (io.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q       <= '0;
            col_q       <= '0;
            win_q       <= 1'b0;
            pend_row_q  <= '0;
            pend_col_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
        end else begin
            row_q       <= row_d;
            col_q       <= col_d;
            win_q       <= win_d;
            pend_row_q  <= pend_row_d;
            pend_col_q  <= pend_col_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
        end
    end

    assign io.pix_ready = pix_ready;
    assign io.out_valid = out_valid_q;
    assign io.out_data  = out_data_q;
    assign io.out_row   = out_row_q;
    assign io.out_col   = out_col_q;
    assign win_valid_o  = win_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule

// File: doc/conv2_sched.md
# conv2_sched

Sequencer for the second convolution layer. Accepts the raster-ordered 12x12 pooled feature stream (all input channels per beat), tracks row/column position, and fires `win_valid` to the 5x5 window buffer and conv2 calc units whenever a complete window exists. It captures each filter's `conv_in` result, adds bias, applies ReLU with saturation, and presents one output beat per window to the pool2 stage over a ready/valid handshake.

## Interface
- `IN_W`, 12: input map width.
- `IN_H`, 12: input map height.
- `K`, 5: kernel size.
- `NUM_FILT`, 3: filters (calc units) scheduled in parallel.
- `DW`, 14: calc-unit result width, signed.
- `OW`, 12: output width per filter, signed, always non-negative.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `start`, in, 1: begin one frame; ignored unless IDLE.
- `pix_valid`, in, 1: input beat valid.
- `pix_ready`, out, 1: input beat accepted when both high.
- `win_valid`, out, 1: one-cycle strobe; window buffer is complete and calc results are sampled this cycle.
- `conv_in`, in, NUM_FILT*DW: calc-unit results, filter f at [f*DW +: DW]; combinational from the window.
- `bias`, in, NUM_FILT*DW: per-filter signed bias, static during a frame.
- `out_valid`, out, 1: output beat valid.
- `out_ready`, in, 1: downstream accepts.
- `out_data`, out, NUM_FILT*OW: per-filter result, same packing.
- `out_row`, out, 3: output row, 0..IN_H-K.
- `out_col`, out, 3: output column, 0..IN_W-K.
- `busy`, out, 1: high in RUN and DRAIN.
- `done`, out, 1: one-cycle pulse at frame end.

## Operation
- States:
  - IDLE: on `start`, go to RUN and clear `row` and `col` to 0.
  - RUN: accept pixels.
  - DRAIN: entered on acceptance of the pixel at `row`=IN_H-1, `col`=IN_W-1.
  - DONE: one cycle, `done`=1, then IDLE.
- DRAIN exits to DONE when `win_valid`=0 and the output register is empty.
- `pix_ready` = RUN && !`win_valid` && !(`out_valid` && !`out_ready`).
- Accepted beat:
  - `col` increments.
  - At `col`=IN_W-1, `col` wraps to 0 and `row` increments.
- Accepted beat with `col`≥K-1 and `row`≥K-1: set the window-pending flag.
  - `win_valid` is registered and is high the next cycle.
  - `out_row`/`out_col` are latched as `row`-(K-1) and `col`-(K-1) of that beat.
- In a `win_valid` cycle, per filter:
  - s = sext(`conv_in`[f]) + sext(`bias`[f]), computed at DW+1 bits.
  - Result = 0 if s<0; 2^(OW-1)-1 (2047) if s>2047; otherwise s[OW-1:0].
  - The result loads the output register; `out_valid` is set.
- `out_valid` clears on `out_ready`. The gating of `pix_ready` guarantees the register is free at every `win_valid` cycle, so no result is ever dropped.
- Each frame produces exactly (IN_H-K+1)*(IN_W-K+1) = 64 beats, in raster order.
- `start` during RUN, DRAIN or DONE: ignored.
- `rst` at any time, including mid-frame, returns to IDLE and clears the counters and the pending window.

## Timing
- Reset values:
  - `pix_ready`, `win_valid`, `out_valid`, `busy`, `done` = 0.
  - `out_data`, `out_row`, `out_col` = 0.
- `start` at cycle t: `busy`=1 and `pix_ready` may be 1 from t+1.
- Qualifying beat accepted at edge t:
  - `win_valid` is high during cycle t+1.
  - `out_valid` is high from t+2.
- Throughput: at most one window per 2 cycles, since `pix_ready`=0 during every `win_valid` cycle.
  - Non-window beats (row<4 or col<4) stream at 1 per cycle.
- With `out_ready` held at 1, `done` pulses on the cycle after the final output handshake at the earliest.
- `out_valid`, `out_data`, `out_row` and `out_col` stay stable while `out_valid`=1 and `out_ready`=0.

## Structure
- Package `conv2_pkg` holds:
  - Constants IN_W, IN_H, K, DW, OW.
  - The state enum {IDLE, RUN, DRAIN, DONE}.
  - Derived OUT_W = IN_W-K+1.
- Sub-module `conv2_bias_relu` implements the combinational add + ReLU + saturate for one filter. It is instantiated NUM_FILT times.
- The counters, FSM, handshake and output register live in `conv2_sched`.

## Test plan
- Full frame, `pix_valid`=1 and `out_ready`=1 always, `conv_in`=100 and `bias`=0 for all filters:
  - Exactly 64 `out_valid` beats, all with `out_data`=100.
  - `out_row`/`out_col` run (0,0)…(7,7).
  - The first `win_valid` occurs 1 cycle after accepting pixel (4,4).
  - `done` pulses once.
- Arithmetic corners, checked per filter:
  - `conv_in`=-50, `bias`=20 → 0.
  - `conv_in`=8191, `bias`=8191 → 2047.
  - `conv_in`=2000, `bias`=47 → 2047.
  - `conv_in`=2000, `bias`=48 → 2047 (saturated).
  - `conv_in`=-8192, `bias`=-8192 → 0.
- Backpressure: `out_ready`=0 for 10 cycles after the first `out_valid`:
  - `pix_ready`=0 throughout.
  - Output beat held stable.
  - No beat is lost or duplicated over the frame (count stays 64).
- Random `pix_valid` gaps plus random `out_ready`: the output sequence and coordinates match the golden model.
- `rst` asserted after 70 accepted pixels:
  - Next cycle all outputs are at reset values and the state is IDLE.
  - A following `start` produces a full correct 64-beat frame.
- `start` pulsed during RUN and during DRAIN: no effect; exactly one `done` per frame.
